// File: rtl/exe_stage_md_if.sv
// ID->EXE->MEM/SRAM bundle of the EXE stage: decoded payload in, result/forwarding/SRAM request out.
// No storage of its own, so no latency.
// Backpressure travels as exe_allowin toward ID and as mem_allowin into EXE.
interface exe_stage_md_if;
    logic        id_to_exe_valid;
    logic        exe_allowin;
    logic [31:0] id_pc;
    logic [75:0] id_alu_data_all;
    logic [6:0]  id_md_op;
    logic [5:0]  id_rf_all;
    logic        id_res_from_mem;
    logic        id_mem_we;
    logic [31:0] id_rkd_value;
    logic        mem_allowin;
    logic        exe_valid;
    logic        exe_to_mem_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic [5:0]  exe_rf_all;
    logic        exe_res_from_mem;
    logic [38:0] exe_fwd_all;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    // EXE stage side
    modport slave (
        input  id_to_exe_valid, id_pc, id_alu_data_all, id_md_op, id_rf_all,
               id_res_from_mem, id_mem_we, id_rkd_value, mem_allowin,
        output exe_allowin, exe_valid, exe_to_mem_valid, exe_pc, exe_result,
               exe_rf_all, exe_res_from_mem, exe_fwd_all,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    // Surrounding pipeline side (ID, MEM, SRAM)
    modport master (
        output id_to_exe_valid, id_pc, id_alu_data_all, id_md_op, id_rf_all,
               id_res_from_mem, id_mem_we, id_rkd_value, mem_allowin,
        input  exe_allowin, exe_valid, exe_to_mem_valid, exe_pc, exe_result,
               exe_rf_all, exe_res_from_mem, exe_fwd_all,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage_md.sv
// EXE stage: ALU, single-cycle 33x33 multiply, iterative restoring divide, data-SRAM request, ID forwarding.
// Latency: ALU/mul result the cycle after latch; a divide is ready 32/DIV_RADIX_LOG2 + 1 cycles after latch.
// Backpressure: holds while a divide is computing or MEM refuses; exe_allowin drops and the result stays stable.
module exe_stage_md #(
    parameter int DIV_RADIX_LOG2 = 1
) (
    input  logic           clk,
    input  logic           resetn,
    exe_stage_md_if.slave  bus
);
    localparam int         N_CALC    = 32 / DIV_RADIX_LOG2;
    localparam logic [4:0] CALC_LAST = 5'(N_CALC - 1);

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

    // alu_op one-hot bits: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [11:0] alu_op_q, alu_op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [6:0]  md_op_q, md_op_d;
    logic [5:0]  rf_all_q, rf_all_d;
    logic        res_from_mem_q, res_from_mem_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] rkd_q, rkd_d;

    div_state_t  div_state_q;
    logic [31:0] quo_q, rem_q, dvs_q;
    logic [4:0]  cnt_q;

    logic        is_mul, is_div, div_signed, is_mod, ready_go, allowin;
    logic [31:0] mag1, mag2, alu_res, mul_res, div_res, exe_res;
    logic [31:0] quo_step, rem_step;
    logic [63:0] mul_a, mul_b, mul_prod;

    assign is_mul     = |md_op_q[2:0];
    assign is_div     = |md_op_q[6:3];
    assign div_signed = md_op_q[3] | md_op_q[4];
    assign is_mod     = md_op_q[4] | md_op_q[6];
    assign ready_go   = ~is_div | (div_state_q == DIV_DONE);
    assign allowin    = ~valid_q | (ready_go & bus.mem_allowin);

    // Payload capture: every field loads together when ID hands over an instruction
    always_comb begin
        valid_d        = valid_q;
        pc_d           = pc_q;
        alu_op_d       = alu_op_q;
        src1_d         = src1_q;
        src2_d         = src2_q;
        md_op_d        = md_op_q;
        rf_all_d       = rf_all_q;
        res_from_mem_d = res_from_mem_q;
        mem_we_d       = mem_we_q;
        rkd_d          = rkd_q;
        if (allowin) begin
            valid_d = bus.id_to_exe_valid;
        end
        if (allowin && bus.id_to_exe_valid) begin
            pc_d                     = bus.id_pc;
            {alu_op_d, src1_d, src2_d} = bus.id_alu_data_all;
            md_op_d                  = bus.id_md_op;
            rf_all_d                 = bus.id_rf_all;
            res_from_mem_d           = bus.id_res_from_mem;
            mem_we_d                 = bus.id_mem_we;
            rkd_d                    = bus.id_rkd_value;
        end
    end

    // Payload registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            alu_op_q       <= '0;
            src1_q         <= '0;
            src2_q         <= '0;
            md_op_q        <= '0;
            rf_all_q       <= '0;
            res_from_mem_q <= 1'b0;
            mem_we_q       <= 1'b0;
            rkd_q          <= '0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            alu_op_q       <= alu_op_d;
            src1_q         <= src1_d;
            src2_q         <= src2_d;
            md_op_q        <= md_op_d;
            rf_all_q       <= rf_all_d;
            res_from_mem_q <= res_from_mem_d;
            mem_we_q       <= mem_we_d;
            rkd_q          <= rkd_d;
        end
    end

    // ALU: one-hot op select
    always_comb begin
        alu_res = '0;
        if      (alu_op_q[0])  alu_res = src1_q + src2_q;
        else if (alu_op_q[1])  alu_res = src1_q - src2_q;
        else if (alu_op_q[2])  alu_res = {31'b0, $signed(src1_q) < $signed(src2_q)};
        else if (alu_op_q[3])  alu_res = {31'b0, src1_q < src2_q};
        else if (alu_op_q[4])  alu_res = src1_q & src2_q;
        else if (alu_op_q[5])  alu_res = ~(src1_q | src2_q);
        else if (alu_op_q[6])  alu_res = src1_q | src2_q;
        else if (alu_op_q[7])  alu_res = src1_q ^ src2_q;
        else if (alu_op_q[8])  alu_res = src1_q << src2_q[4:0];
        else if (alu_op_q[9])  alu_res = src1_q >> src2_q[4:0];
        else if (alu_op_q[10]) alu_res = 32'($signed(src1_q) >>> src2_q[4:0]);
        else if (alu_op_q[11]) alu_res = src2_q;
    end

    // Multiply: 64-bit product of sign/zero-extended operands equals the low half of the 33x33 product
    always_comb begin
        mul_a    = {{32{~md_op_q[2] & src1_q[31]}}, src1_q};
        mul_b    = {{32{~md_op_q[2] & src2_q[31]}}, src2_q};
        mul_prod = mul_a * mul_b;
        mul_res  = md_op_q[0] ? mul_prod[31:0] : mul_prod[63:32];
    end

    // Divider step: DIV_RADIX_LOG2 restoring iterations on {rem, quo} per CALC cycle
    always_comb begin
        logic [32:0] shifted;
        logic [33:0] diff;
        quo_step = quo_q;
        rem_step = rem_q;
        for (int i = 0; i < DIV_RADIX_LOG2; i++) begin
            shifted  = {rem_step, quo_step[31]};
            diff     = {1'b0, shifted} - {2'b0, dvs_q};
            quo_step = {quo_step[30:0], ~diff[33]};
            rem_step = diff[33] ? 32'(shifted) : 32'(diff);
        end
    end

    // Operand magnitudes and sign fixup; a zero divisor overrides everything
    always_comb begin
        mag1    = (div_signed & src1_q[31]) ? (32'd0 - src1_q) : src1_q;
        mag2    = (div_signed & src2_q[31]) ? (32'd0 - src2_q) : src2_q;
        div_res = is_mod ? ((div_signed & src1_q[31]) ? (32'd0 - rem_q) : rem_q)
                         : ((div_signed & (src1_q[31] ^ src2_q[31])) ? (32'd0 - quo_q) : quo_q);
        if (src2_q == 32'd0) begin
            div_res = is_mod ? src1_q : 32'hFFFF_FFFF;
        end
    end

    // Divide FSM: load magnitudes, run N_CALC steps, hold in DONE until MEM takes the result
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_state_q <= DIV_IDLE;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (valid_q && is_div) begin
                        div_state_q <= DIV_CALC;
                        quo_q       <= mag1;
                        rem_q       <= '0;
                        dvs_q       <= mag2;
                        cnt_q       <= '0;
                    end
                end
                DIV_CALC: begin
                    quo_q <= quo_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == CALC_LAST) begin
                        div_state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (bus.mem_allowin) begin
                        div_state_q <= DIV_IDLE;
                    end
                end
                default: div_state_q <= DIV_IDLE;
            endcase
        end
    end

    assign exe_res = is_div ? div_res : (is_mul ? mul_res : alu_res);

    assign bus.exe_allowin      = allowin;
    assign bus.exe_valid        = valid_q;
    assign bus.exe_to_mem_valid = valid_q & ready_go;
    assign bus.exe_pc           = pc_q;
    assign bus.exe_result       = exe_res;
    assign bus.exe_rf_all       = rf_all_q;
    assign bus.exe_res_from_mem = res_from_mem_q;
    assign bus.exe_fwd_all      = {valid_q & (res_from_mem_q | (is_div & (div_state_q != DIV_DONE))),
                                   rf_all_q, exe_res};
    assign bus.data_sram_en     = valid_q & (res_from_mem_q | mem_we_q) & bus.mem_allowin;
    assign bus.data_sram_we     = {4{valid_q & mem_we_q & bus.mem_allowin}};
    assign bus.data_sram_addr   = alu_res;
    assign bus.data_sram_wdata  = rkd_q;
endmodule

// File: tb/tb_exe_stage_md.sv
// Directed bench for exe_stage_md: ALU back-to-back, mul variants, div/mod corner cases, stall and reset.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
// MEM backpressure is exercised by holding mem_allowin low while a store or a finished divide sits in EXE.
module tb_exe_stage_md;
    localparam int N_CALC = 32;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [6:0]  MD_NONE = 7'b0000000, MD_MUL = 7'b0000001, MD_MULH = 7'b0000010,
                            MD_MULHU = 7'b0000100, MD_DIV = 7'b0001000, MD_MOD = 7'b0010000,
                            MD_DIVU = 7'b0100000, MD_MODU = 7'b1000000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exe_stage_md_if bif ();

    exe_stage_md #(.DIV_RADIX_LOG2(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [11:0] aop, input logic [6:0] md,
                         input logic [31:0] s1, input logic [31:0] s2);
        bif.id_to_exe_valid = 1'b1;
        bif.id_pc           = 32'h1c00_0000 + s2;
        bif.id_alu_data_all = {aop, s1, s2};
        bif.id_md_op        = md;
        bif.id_rf_all       = 6'h25;
        bif.id_res_from_mem = 1'b0;
        bif.id_mem_we       = 1'b0;
        bif.id_rkd_value    = 32'h0;
    endtask

    // Issue one divide with MEM open, measure latch-to-ready latency and the result, then retire it
    task automatic run_div(input string tag, input logic [6:0] md,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] exp);
        int  lat;
        bit  nr_ok;
        issue(OP_ADD, md, s1, s2);
        tick();
        bif.id_to_exe_valid = 1'b0;
        lat   = 0;
        nr_ok = 1'b1;
        while (!bif.exe_to_mem_valid && lat < 200) begin
            if (bif.exe_fwd_all[38] !== 1'b1 || bif.exe_allowin !== 1'b0) nr_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(N_CALC + 1));
        chk({tag, "_stall_flags"}, 64'(nr_ok), 64'd1);
        chk({tag, "_result"}, 64'(bif.exe_result), 64'(exp));
        chk({tag, "_not_ready_done"}, 64'(bif.exe_fwd_all[38]), 64'd0);
        tick();
        chk({tag, "_retired"}, 64'(bif.exe_valid), 64'd0);
    endtask

    initial begin
        bif.id_to_exe_valid = 1'b0;
        bif.id_pc           = '0;
        bif.id_alu_data_all = '0;
        bif.id_md_op        = '0;
        bif.id_rf_all       = '0;
        bif.id_res_from_mem = 1'b0;
        bif.id_mem_we       = 1'b0;
        bif.id_rkd_value    = '0;
        bif.mem_allowin     = 1'b1;

        // Reset state
        tick(); tick(); tick();
        chk("rst_valid", 64'(bif.exe_valid), 64'd0);
        chk("rst_allowin", 64'(bif.exe_allowin), 64'd1);
        chk("rst_to_mem", 64'(bif.exe_to_mem_valid), 64'd0);
        chk("rst_sram_en", 64'(bif.data_sram_en), 64'd0);
        resetn = 1'b1;
        tick();

        // Back-to-back add then sub
        issue(OP_ADD, MD_NONE, 32'd3, 32'd4);
        tick();
        chk("add_result", 64'(bif.exe_result), 64'd7);
        chk("add_to_mem", 64'(bif.exe_to_mem_valid), 64'd1);
        chk("add_fwd", 64'(bif.exe_fwd_all), {25'd0, 1'b0, 6'h25, 32'd7});
        chk("add_pc", 64'(bif.exe_pc), 64'h1c00_0004);
        issue(OP_SUB, MD_NONE, 32'd10, 32'd1);
        tick();
        chk("sub_result", 64'(bif.exe_result), 64'd9);
        chk("sub_valid", 64'(bif.exe_valid), 64'd1);

        // Load: address from ALU, forwarding marks not ready
        issue(OP_ADD, MD_NONE, 32'h100, 32'h4);
        bif.id_res_from_mem = 1'b1;
        tick();
        chk("ld_sram_en", 64'(bif.data_sram_en), 64'd1);
        chk("ld_sram_we", 64'(bif.data_sram_we), 64'h0);
        chk("ld_addr", 64'(bif.data_sram_addr), 64'h104);
        chk("ld_not_ready", 64'(bif.exe_fwd_all[38]), 64'd1);
        chk("ld_res_from_mem", 64'(bif.exe_res_from_mem), 64'd1);

        // Store, then MEM stalls: no SRAM access and no accept while stalled
        issue(OP_ADD, MD_NONE, 32'h200, 32'h8);
        bif.id_mem_we    = 1'b1;
        bif.id_rkd_value = 32'hDEAD_BEEF;
        tick();
        chk("st_sram_we", 64'(bif.data_sram_we), 64'hF);
        chk("st_wdata", 64'(bif.data_sram_wdata), 64'hDEAD_BEEF);
        bif.id_to_exe_valid = 1'b0;
        bif.mem_allowin     = 1'b0;
        #1;
        chk("st_stall_we", 64'(bif.data_sram_we), 64'h0);
        chk("st_stall_en", 64'(bif.data_sram_en), 64'd0);
        chk("st_stall_allowin", 64'(bif.exe_allowin), 64'd0);
        tick();
        chk("st_stall_held", 64'(bif.exe_valid), 64'd1);
        bif.mem_allowin = 1'b1;
        tick();
        chk("st_left", 64'(bif.exe_valid), 64'd0);

        // Signed and unsigned division corners
        run_div("div_w_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod_w_m7_2", MD_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div_wu_by0", MD_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        run_div("mod_wu_by0", MD_MODU, 32'h8000_0000, 32'd0, 32'h8000_0000);
        run_div("div_w_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("mod_w_ovf", MD_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Multiplies, back to back
        issue(OP_ADD, MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk("mul_w", 64'(bif.exe_result), 64'h1);
        issue(OP_ADD, MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk("mulh_w", 64'(bif.exe_result), 64'h0);
        issue(OP_ADD, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        chk("mulh_wu", 64'(bif.exe_result), 64'hFFFF_FFFE);
        bif.id_to_exe_valid = 1'b0;
        tick();

        // Divide finishes while MEM refuses: result and stall held
        issue(OP_ADD, MD_DIVU, 32'd100, 32'd7);
        bif.mem_allowin = 1'b0;
        tick();
        bif.id_to_exe_valid = 1'b0;
        begin
            int lat = 0;
            while (!bif.exe_to_mem_valid && lat < 200) begin
                tick();
                lat++;
            end
            chk("hold_latency", 64'(lat), 64'(N_CALC + 1));
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_result", 64'(bif.exe_result), 64'd14);
            chk("hold_allowin", 64'(bif.exe_allowin), 64'd0);
            tick();
        end
        bif.mem_allowin = 1'b1;
        tick();
        chk("hold_released", 64'(bif.exe_valid), 64'd0);

        // Reset in the middle of CALC, then a fresh divide runs at full length
        issue(OP_ADD, MD_DIV, 32'd1000, 32'd3);
        tick();
        bif.id_to_exe_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        resetn = 1'b0;
        tick();
        chk("midcalc_rst_valid", 64'(bif.exe_valid), 64'd0);
        chk("midcalc_rst_not_ready", 64'(bif.exe_fwd_all[38]), 64'd0);
        resetn = 1'b1;
        tick();
        run_div("after_rst_div", MD_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
